prim_arbiter_wrr: RTL
=====================

# prim_arbiter_wrr

N:1 weighted round-robin arbiter with per-requester burst credit and a combinational valid/ready output handshake. It replaces the plain round-robin arbiter wherever requesters need unequal bandwidth shares, for example bus hosts or DMA channels feeding one TL-UL port. Grant is combinational. Turn ownership, credit and the not-ready lock are registered.

## Interface
- N, 4, number of requesters; must be ≥ 2.
- DW, 32, data width.
- WW, 4, weight width; a turn lasts weight+1 accepted beats (1..2^WW).
- EnDataPort, 1, when 0, data_i is ignored and data_o is constant all-ones.
- IdxW, $clog2(N), derived localparam.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  N  request per requester.
- data_i  in  DW × [N]  per-requester payload.
- weight_i  in  WW × [N]  per-requester weight; sampled only at turn start.
- last_i  in  N  end-of-packet marker per requester; present only with PRIM_ARB_WRR_PKT_LOCK_EN.
- gnt_o  out  N  one-hot0 grant, equal to winner & {N{ready_i}}.
- idx_o  out  IdxW  winner index; 0 when no request.
- valid_o  out  1  |req_i.
- data_o  out  DW  data_i[idx_o]; 0 when no request.
- ready_i  in  1  sink ready.

## Operation
State:
- cur: IdxW bits, current or last owner.
- hold: 1 bit, owner turn in progress.
- cred: WW bits, beats remaining after the current beat.
- lock: 1 bit, decision frozen because the sink is not ready.
- lidx: IdxW bits, frozen winner index.

Winner selection, first rule that matches:
1. lock && req_i[lidx] → lidx.
2. hold && req_i[cur] → cur.
3. Otherwise, the first set req_i bit scanning cur+1, cur+2, … with wrap-around, ending at cur.

Handshake: a beat is accepted when valid_o && ready_i.

Updates on an accepted beat:
- New owner (winner from rule 3): cur←winner, cred←weight_i[winner], hold←(weight_i[winner]≠0).
- Held owner (rule 1 or 2 with winner==cur and hold set): if cred==1, hold←0; cred←cred−1.

Not-ready lock:
- valid_o && !ready_i → lock←1, lidx←winner. cur, hold and cred are unchanged.
- Any accepted beat, or !valid_o → lock←0.

Boundary conditions:
- Owner drops req_i while hold is set: hold is cleared at the next edge. Remaining credit is forfeited and the scan resumes at cur+1.
- weight_i changes mid-turn: no effect until the next turn starts.
- A single requester is granted every accepted beat, re-starting turns back to back.
- Requests are required to stay high until granted while locked. If a locked requester drops, selection falls through to rules 2 and 3.

## Timing
- Grant, idx, data and valid are combinational from req_i, ready_i and state; zero latency.
- State updates on the rising edge of clk_i.
- Reset (rst_i=1 at an edge) takes priority over every other update: cur←N−1 (first scan starts at index 0), hold←0, cred←0, lock←0.
- A reset asserted mid-turn discards the turn. The first cycle after reset arbitrates from index 0.
- Outputs during and after reset with req_i=0: gnt_o=0, idx_o=0, valid_o=0, data_o=0 (all-ones when EnDataPort=0).

## Configuration
- PRIM_ARB_WRR_PKT_LOCK_EN defined:
  - The last_i port exists.
  - On a held beat with cred==1 and last_i[cur]==0, hold stays 1 and cred stays 0.
  - When cred==0 and hold is set, hold clears only on an accepted beat with last_i[cur]==1.
  - A new owner with weight 0 gets hold←!last_i[winner].
  - Net effect: turns never end mid-packet.
- Undefined: the last_i port is absent and turns end purely on credit.

## Test plan
- Weights {0,1,2,0}, req_i=4'b1111, ready_i=1 for 14 cycles → idx_o sequence 0,1,1,2,2,2,3,0,1,1,2,2,2,3.
- req_i=4'b0110, ready_i=0 for 3 cycles, then 1 → idx_o=1 on all four cycles; gnt_o=4'b0010 only on the 4th cycle.
- Weight 3 on requester 2 only; drop req_i[2] after 2 beats, then re-raise it → next grant to requester 2 starts a fresh 4-beat turn. The scan passes index 3 and wraps first if other requesters are active.
- rst_i pulsed mid-turn of requester 2 while all requests are high → first grant after reset goes to index 0.
- With PRIM_ARB_WRR_PKT_LOCK_EN: weights all 0, req_i=4'b0011, last_i[0] low for 3 beats then high → requester 0 granted 4 beats, then requester 1.
- EnDataPort=0 → data_o=all-ones on every cycle, with or without requests.

Source files
------------

// File: rtl/prim_arbiter_wrr.sv
// ---------------------------------------------------------------------------
// prim_arbiter_wrr
//
// N:1 weighted round-robin arbiter with per-requester burst credit and a
// combinational valid/ready output handshake. A requester that wins a fresh
// turn keeps the grant for weight+1 accepted beats, as long as it keeps
// requesting. While the sink is not ready the current decision is frozen, so
// the winner cannot change under a stalled beat.
//
// Optional feature macro: PRIM_ARB_WRR_PKT_LOCK_EN
//   When defined, a last_i port is added and a turn is extended until the
//   owner's end-of-packet beat, so turns never end in the middle of a packet.
//
// Parameters:
//   N          number of requesters (>= 2)
//   DW         payload width
//   WW         weight width; a turn lasts weight+1 accepted beats
//   EnDataPort 0: data_i is ignored and data_o is constant all-ones
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   req_i     per-requester request
//   data_i    per-requester payload
//   weight_i  per-requester weight, sampled when a turn starts
//   last_i    per-requester end-of-packet marker (packet-lock build only)
//   gnt_o     one-hot0 grant, winner qualified by ready_i
//   idx_o     winner index, 0 when nothing requests
//   valid_o   any request pending
//   data_o    winner payload, 0 when nothing requests
//   ready_i   sink ready
// ---------------------------------------------------------------------------
module prim_arbiter_wrr #(
  parameter int unsigned N          = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned WW         = 4,
  parameter bit          EnDataPort = 1'b1,
  localparam int unsigned IdxW      = $clog2(N)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N-1:0]           req_i,
  input  logic [N-1:0][DW-1:0]   data_i,
  input  logic [N-1:0][WW-1:0]   weight_i,
`ifdef PRIM_ARB_WRR_PKT_LOCK_EN
  input  logic [N-1:0]           last_i,
`endif
  output logic [N-1:0]           gnt_o,
  output logic [IdxW-1:0]        idx_o,
  output logic                   valid_o,
  output logic [DW-1:0]          data_o,
  input  logic                   ready_i
);

  // Turn ownership and the stall freeze.
  logic [IdxW-1:0] cur_q;   // current or most recent owner
  logic            hold_q;  // owner turn in progress
  logic [WW-1:0]   cred_q;  // beats left after the current one
  logic            lock_q;  // decision frozen by a stalled beat
  logic [IdxW-1:0] lidx_q;  // frozen winner

  logic [IdxW-1:0] scan_idx;
  logic [IdxW-1:0] win_idx;
  logic            use_lock;
  logic            use_hold;
  logic            accept;
  logic            held_beat;

  // Rotating scan: the first requester after cur_q, wrapping back to cur_q.
  // Walking offsets from far to near lets the nearest match overwrite the
  // others, so no early exit is needed.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    scan_idx = cur_q;
    for (int off = int'(N); off >= 1; off--) begin
      if (req_i[IdxW'((int'(cur_q) + off) % int'(N))]) begin
        scan_idx = IdxW'((int'(cur_q) + off) % int'(N));
      end
    end
  end

  assign use_lock = lock_q && req_i[lidx_q];
  assign use_hold = hold_q && req_i[cur_q];
  assign win_idx  = use_lock ? lidx_q : (use_hold ? cur_q : scan_idx);

  assign valid_o  = |req_i;
  assign accept   = valid_o && ready_i;
  // A beat continues the running turn only if the owner itself wins again;
  // anything else (including a frozen non-owner) starts a new turn.
  assign held_beat = hold_q && req_i[cur_q] && (win_idx == cur_q);

  always_comb begin
    gnt_o = '0;
    if (accept) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  assign idx_o = valid_o ? win_idx : '0;

  always_comb begin
    if (!EnDataPort) begin
      data_o = '1;
    end else if (valid_o) begin
      data_o = data_i[win_idx];
    end else begin
      data_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registered state is written only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      cur_q  <= IdxW'(N - 1);  // first scan after reset starts at index 0
      hold_q <= 1'b0;
      cred_q <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else if (accept) begin
      lock_q <= 1'b0;
      if (held_beat) begin
        if (cred_q > WW'(1)) begin
          cred_q <= cred_q - WW'(1);
        end else begin
          cred_q <= '0;
`ifdef PRIM_ARB_WRR_PKT_LOCK_EN
          // Credit exhausted: the turn survives until the packet ends.
          hold_q <= !last_i[cur_q];
`else
          hold_q <= 1'b0;
`endif
        end
      end else begin
        cur_q  <= win_idx;
        cred_q <= weight_i[win_idx];
`ifdef PRIM_ARB_WRR_PKT_LOCK_EN
        hold_q <= (weight_i[win_idx] != '0) || !last_i[win_idx];
`else
        hold_q <= (weight_i[win_idx] != '0);
`endif
      end
    end else begin
      // Stalled beat freezes the winner; an idle cycle releases the freeze.
      lock_q <= valid_o;
      if (valid_o) begin
        lidx_q <= win_idx;
      end
      // An owner that stops requesting forfeits the rest of its turn.
      if (hold_q && !req_i[cur_q]) begin
        hold_q <= 1'b0;
      end
    end
  end

endmodule
